// File: rtl/compare_tally.sv
// compare_tally: collects results from the 3-bit magnitude comparator, checks
// that each result is one-hot, and tallies greater/equal/less/error samples.
// After BATCH samples it holds a report until the out_valid/out_ready
// handshake, then clears the tallies for the next batch.
// Optional feature macro: TALLY_SELFCHECK_EN recomputes the comparison from
// a and b and also flags a sample as an error when its flags disagree.
module compare_tally #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned BATCH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       a,
    input  logic [2:0]       b,
    input  logic             a_gt_b,
    input  logic             a_eq_b,
    input  logic             a_lt_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag
);

    localparam int unsigned SEQ_W = $clog2(BATCH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state;
    logic [SEQ_W-1:0] seq_cnt;
    logic [2:0]       flags;
    logic             one_hot;
    logic             is_err;
    logic             accept;
    logic             last_sample;
    logic             report_done;

    assign flags       = {a_gt_b, a_eq_b, a_lt_b};
    assign in_ready    = rst_n && (state != REPORT);
    assign accept      = in_valid && in_ready;
    assign last_sample = (seq_cnt == SEQ_W'(BATCH - 1));
    assign report_done = (state == REPORT) && out_ready;

    // Exactly one flag set marks a structurally valid comparator result.
    always_comb begin
        one_hot = 1'b0;
        case (flags)
            3'b100, 3'b010, 3'b001: one_hot = 1'b1;
            default:                one_hot = 1'b0;
        endcase
    end

`ifdef TALLY_SELFCHECK_EN
    logic [2:0] ref_flags;

    // Recompute the comparison locally; any disagreement is an error.
    always_comb begin
        ref_flags = {a > b, a == b, a < b};
        is_err    = !one_hot || (flags != ref_flags);
    end
`else
    logic unused_operands;
    assign unused_operands = ^{a, b};

    // Without self-check only the one-hot property classifies errors.
    always_comb begin
        is_err = !one_hot;
    end
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Batch sequencing: counts accepted samples and holds the report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            seq_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        seq_cnt <= seq_cnt + SEQ_W'(1);
                        if (last_sample) begin
                            state     <= REPORT;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        seq_cnt   <= '0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    seq_cnt   <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Saturating tallies; cleared on the report handshake, err_flag is sticky.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gt_count  <= '0;
            eq_count  <= '0;
            lt_count  <= '0;
            err_count <= '0;
            err_flag  <= 1'b0;
        end else if (report_done) begin
            gt_count  <= '0;
            eq_count  <= '0;
            lt_count  <= '0;
            err_count <= '0;
        end else if (accept) begin
            if (is_err) begin
                err_count <= sat_inc(err_count);
                err_flag  <= 1'b1;
            end else if (a_gt_b) begin
                gt_count <= sat_inc(gt_count);
            end else if (a_eq_b) begin
                eq_count <= sat_inc(eq_count);
            end else begin
                lt_count <= sat_inc(lt_count);
            end
        end
    end

endmodule

// File: tb/tb_compare_tally.sv
// Directed testbench for compare_tally: several instances with different
// BATCH/CNT_W share operand and flag inputs; each has its own in_valid.
module tb_compare_tally;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] vld;
    logic [2:0] a, b;
    logic       gt, eq, lt;
    logic       out_ready;

    // Instance index: 0=BATCH3, 1=BATCH2, 2=saturation, 3=BATCH8, 4=BATCH1
    logic [4:0] rdy, ov, ef;
    logic [7:0] gt0, eq0, lt0, er0, gt1, eq1, lt1, er1;
    logic [7:0] gt3, eq3, lt3, er3, gt4, eq4, lt4, er4;
    logic [1:0] gt2, eq2, lt2, er2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    compare_tally #(.CNT_W(8), .BATCH(3)) u_b3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[0]), .in_ready(rdy[0]),
        .a(a), .b(b), .a_gt_b(gt), .a_eq_b(eq), .a_lt_b(lt),
        .out_valid(ov[0]), .out_ready(out_ready), .gt_count(gt0), .eq_count(eq0),
        .lt_count(lt0), .err_count(er0), .err_flag(ef[0]));

    compare_tally #(.CNT_W(8), .BATCH(2)) u_b2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[1]), .in_ready(rdy[1]),
        .a(a), .b(b), .a_gt_b(gt), .a_eq_b(eq), .a_lt_b(lt),
        .out_valid(ov[1]), .out_ready(out_ready), .gt_count(gt1), .eq_count(eq1),
        .lt_count(lt1), .err_count(er1), .err_flag(ef[1]));

    compare_tally #(.CNT_W(2), .BATCH(6)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[2]), .in_ready(rdy[2]),
        .a(a), .b(b), .a_gt_b(gt), .a_eq_b(eq), .a_lt_b(lt),
        .out_valid(ov[2]), .out_ready(out_ready), .gt_count(gt2), .eq_count(eq2),
        .lt_count(lt2), .err_count(er2), .err_flag(ef[2]));

    compare_tally #(.CNT_W(8), .BATCH(8)) u_b8 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[3]), .in_ready(rdy[3]),
        .a(a), .b(b), .a_gt_b(gt), .a_eq_b(eq), .a_lt_b(lt),
        .out_valid(ov[3]), .out_ready(out_ready), .gt_count(gt3), .eq_count(eq3),
        .lt_count(lt3), .err_count(er3), .err_flag(ef[3]));

    compare_tally #(.CNT_W(8), .BATCH(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vld[4]), .in_ready(rdy[4]),
        .a(a), .b(b), .a_gt_b(gt), .a_eq_b(eq), .a_lt_b(lt),
        .out_valid(ov[4]), .out_ready(out_ready), .gt_count(gt4), .eq_count(eq4),
        .lt_count(lt4), .err_count(er4), .err_flag(ef[4]));

    // Single comparison point: counts and reports any mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one sample to instance idx for one rising edge (call at negedge).
    task automatic feed(input int idx, input logic [2:0] aa, input logic [2:0] bb,
                        input logic [2:0] flg);
        vld    = '0;
        vld[idx] = 1'b1;
        a = aa;  b = bb;
        {gt, eq, lt} = flg;
        @(posedge clk);
        @(negedge clk);
        vld = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "time limit");
    end

    initial begin
        vld = '0; a = '0; b = '0; gt = 0; eq = 0; lt = 0;
        out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        tick();

        // Reset values
        check("rst_in_ready", 32'(rdy[0]), 0);
        check("rst_out_valid", 32'(ov[0]), 0);
        check("rst_tallies", 32'({gt0, eq0, lt0, er0}), 0);
        check("rst_err_flag", 32'(ef[0]), 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(rdy[0]), 1);

        // Basic tally, BATCH=3
        feed(0, 3'b110, 3'b001, 3'b100);
        check("basic_not_yet", 32'(ov[0]), 0);
        check("basic_gt_latency", 32'(gt0), 1);
        feed(0, 3'b010, 3'b011, 3'b001);
        feed(0, 3'b101, 3'b100, 3'b100);
        check("basic_out_valid", 32'(ov[0]), 1);
        check("basic_gt", 32'(gt0), 2);
        check("basic_eq", 32'(eq0), 0);
        check("basic_lt", 32'(lt0), 1);
        check("basic_err", 32'(er0), 0);
        check("basic_err_flag", 32'(ef[0]), 0);
        check("basic_in_ready", 32'(rdy[0]), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("basic_release_ov", 32'(ov[0]), 0);
        check("basic_release_gt", 32'(gt0), 0);
        check("basic_release_rdy", 32'(rdy[0]), 1);

        // Error detection, BATCH=2
        feed(1, 3'b011, 3'b011, 3'b100);
        feed(1, 3'b000, 3'b000, 3'b011);
        check("err_out_valid", 32'(ov[1]), 1);
`ifdef TALLY_SELFCHECK_EN
        check("err_err", 32'(er1), 2);
        check("err_gt", 32'(gt1), 0);
`else
        check("err_err", 32'(er1), 1);
        check("err_gt", 32'(gt1), 1);
`endif
        check("err_eq", 32'(eq1), 0);
        check("err_lt", 32'(lt1), 0);
        check("err_flag", 32'(ef[1]), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("err_flag_sticky", 32'(ef[1]), 1);
        check("err_cleared", 32'(er1), 0);

        // Back-pressure, BATCH=2, in_valid held during REPORT
        feed(1, 3'b101, 3'b101, 3'b010);
        feed(1, 3'b101, 3'b101, 3'b010);
        vld[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(rdy[1]), 0);
            check("bp_out_valid", 32'(ov[1]), 1);
            check("bp_eq_stable", 32'(eq1), 2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        vld = '0;
        out_ready = 1'b0;
        check("bp_release_ov", 32'(ov[1]), 0);
        check("bp_release_eq", 32'(eq1), 0);
        check("bp_release_rdy", 32'(rdy[1]), 1);

        // Saturation, CNT_W=2, BATCH=6
        for (int i = 0; i < 5; i++) feed(2, 3'b101, 3'b101, 3'b010);
        check("sat_no_early_report", 32'(ov[2]), 0);
        check("sat_eq_held", 32'(eq2), 3);
        feed(2, 3'b101, 3'b101, 3'b010);
        check("sat_out_valid", 32'(ov[2]), 1);
        check("sat_eq", 32'(eq2), 3);

        // Reset mid-batch, BATCH=8
        for (int i = 0; i < 4; i++) feed(3, 3'b111, 3'b001, 3'b100);
        check("mid_gt_before", 32'(gt3), 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_gt_reset", 32'(gt3), 0);
        check("mid_ov_reset", 32'(ov[3]), 0);
        check("mid_sat_ov_reset", 32'(ov[2]), 0);
        check("mid_flag_reset", 32'(ef[1]), 0);
        for (int i = 0; i < 7; i++) feed(3, 3'b111, 3'b001, 3'b100);
        check("mid_no_early_report", 32'(ov[3]), 0);
        feed(3, 3'b111, 3'b001, 3'b100);
        check("mid_out_valid", 32'(ov[3]), 1);
        check("mid_gt8", 32'(gt3), 8);

        // Operands disagree with flags, BATCH=1
        feed(4, 3'b000, 3'b111, 3'b100);
        check("b1_out_valid", 32'(ov[4]), 1);
`ifdef TALLY_SELFCHECK_EN
        check("b1_gt", 32'(gt4), 0);
        check("b1_err", 32'(er4), 1);
`else
        check("b1_gt", 32'(gt4), 1);
        check("b1_err", 32'(er4), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
